cfg_word_rx: RTL and testbench
==============================

Name: cfg_word_rx

Overview:
- Receive end of the serial column-configuration interface (o_col_write / o_data / i_col_rdy).
- Samples one data bit per write strobe, MSB first, and answers each strobe with a one-cycle ready pulse after a programmable delay.
- Assembles LEN-bit words and hands them to a consumer over a valid/ack handshake.
- Used as the sensor-side column register model in loopback benches and as the FPGA-side readback deserializer; also flags protocol, timeout and overrun errors.

Parameters:
- LEN, 7: bits per configuration word; must be at least 2.
- RDY_DLY, 2: cycles from the sampled strobe to the o_col_rdy pulse; must be at least 1.
- TIMEOUT, 64: maximum idle cycles between strobes inside a word; 0 disables the check.

Ports:
- clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_clr  in  1  synchronous clear of the sticky error flags
- i_col_write  in  1  write strobe, one cycle per bit
- i_data  in  1  serial data, sampled when i_col_write=1
- i_ack  in  1  consumer accepts o_word
- o_col_rdy  out  1  ready pulse back to the transmitter
- o_word  out  LEN  last completed word, MSB is the first bit received
- o_valid  out  1  o_word holds an unaccepted word
- o_bit_cnt  out  clog2(LEN+1)  bits captured in the current partial word
- o_err_proto  out  1  sticky: strobe arrived while busy
- o_err_timeout  out  1  sticky: inter-bit gap exceeded TIMEOUT
- o_overrun  out  1  sticky: word completed while o_valid=1 and i_ack=0

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; shift register, bit count, o_word and all counters go to 0.
  - o_col_rdy, o_valid and all error flags go to 0.
  - Applies immediately, including mid-word; any partial word is lost.
- States: IDLE (no partial word), DELAY (counting toward ready), RDY (ready pulse), GAP (partial word, waiting for the next strobe).
- Capture, in IDLE or GAP with i_col_write=1:
  - At that edge: sr <= {sr[LEN-2:0], i_data}, bit_cnt++.
  - Next state is DELAY, or RDY when RDY_DLY=1.
- DELAY:
  - Stays for RDY_DLY-1 cycles, then moves to RDY.
  - o_col_rdy is therefore high exactly RDY_DLY cycles after the strobe cycle.
- RDY:
  - o_col_rdy=1 for exactly one cycle, decoded from registered state only (no combinational path from inputs).
  - Next state is IDLE if bit_cnt=0 (word just completed), otherwise GAP.
  - A ready pulse is issued after the LEN-th bit as well; the transmitter needs it to return to idle.
- Word completion, on the strobe that captures bit LEN:
  - At the same edge: o_word <= {sr[LEN-2:0], i_data}, bit_cnt <= 0, o_valid <= 1.
  - If o_valid=1 and i_ack=0 at that edge: o_word and o_valid are kept, the new word is discarded, and o_overrun is set.
  - If i_ack=1 at that edge: the new word loads, o_valid stays 1, no overrun.
- Ack: with o_valid=1 and i_ack=1 and no completion at that edge, o_valid <= 0. i_ack while o_valid=0 is ignored.
- Protocol error: i_col_write=1 in DELAY or RDY sets o_err_proto. The bit is ignored and the state sequence is unaffected.
- Timeout (TIMEOUT>0):
  - The gap counter resets on entry to GAP and increments each cycle spent in GAP.
  - When it reaches TIMEOUT with no strobe: o_err_timeout is set, sr and bit_cnt are cleared, and the state returns to IDLE.
  - A strobe arriving in the same cycle as the timeout wins: the bit is captured and no error is raised.
- i_clr clears all three sticky flags. An error event in the same cycle as i_clr wins, so the flag ends up set.
- Counter widths: dly_cnt is clog2(RDY_DLY+1) bits and gap_cnt is clog2(TIMEOUT+1) bits; both saturate, never wrap.
- o_bit_cnt reflects the registered bit_cnt.

Test Plan:
- Loopback with cfg_word_sr (LEN=7, RDY_DLY=2), load 7'b1011001 -> seven strobes each followed 2 cycles later by one rdy pulse; o_word=7'h59; o_valid rises one cycle after the 7th strobe; transmitter returns to ready.
- RDY_DLY=1, strobe at cycle t -> o_col_rdy high at t+1 only; RDY_DLY=5 -> high at t+5 only.
- Two words back-to-back, i_ack held 0 -> first word retained, o_overrun=1; repeat with i_ack=1 on the completing edge -> second word loaded, o_overrun=0.
- TIMEOUT=8, send 3 bits then stop -> o_err_timeout=1 after 8 GAP cycles, o_bit_cnt=0; next 7 strobes yield a correct word.
- Strobe injected one cycle after a sampled strobe (RDY_DLY=3) -> o_err_proto=1 and the bit is not captured; i_clr pulse -> flag 0; i_clr coincident with a new violation -> flag stays 1.
- Assert i_rst_n=0 after 4 bits -> all outputs 0 at once; after release, a full word of 7'h2A is received intact.

Source files
------------

// File: rtl/cfg_word_rx.sv
// Receive side of the serial column-configuration link: captures one bit per
// write strobe, answers with a delayed ready pulse and assembles LEN-bit words.
module cfg_word_rx #(
    parameter int LEN     = 7,
    parameter int RDY_DLY = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic                       i_clr,
    input  logic                       i_col_write,
    input  logic                       i_data,
    input  logic                       i_ack,
    output logic                       o_col_rdy,
    output logic [LEN-1:0]             o_word,
    output logic                       o_valid,
    output logic [$clog2(LEN+1)-1:0]   o_bit_cnt,
    output logic                       o_err_proto,
    output logic                       o_err_timeout,
    output logic                       o_overrun
);

    localparam int BW = $clog2(LEN+1);
    localparam int DW = $clog2(RDY_DLY+1);
    localparam int GW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(LEN-1);
    localparam logic [DW-1:0] DLY_LAST = DW'(RDY_DLY-1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT-1);

    typedef enum logic [1:0] {IDLE, DELAY, RDY, GAP} state_t;

    state_t          state, state_nx;
    logic [LEN-2:0]  sr;
    logic [LEN-1:0]  shifted;
    logic [BW-1:0]   bit_cnt;
    logic [DW-1:0]   dly_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            capture, complete, proto, tmo, overrun_evt;

    // Only the LEN-1 most recent bits are kept; the strobed bit completes the word.
    assign shifted     = {sr, i_data};
    assign complete    = capture && (bit_cnt == LAST_BIT);
    assign overrun_evt = complete && o_valid && !i_ack;
    assign o_col_rdy   = (state == RDY);
    assign o_bit_cnt   = bit_cnt;

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        proto    = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (i_col_write) begin
                    capture  = 1'b1;
                    state_nx = (RDY_DLY == 1) ? RDY : DELAY;
                end else if (state == GAP && TIMEOUT > 0 && gap_cnt >= GAP_LAST) begin
                    tmo      = 1'b1;
                    state_nx = IDLE;
                end
            end
            DELAY: begin
                proto = i_col_write;
                if (dly_cnt >= DLY_LAST) state_nx = RDY;
            end
            RDY: begin
                proto    = i_col_write;
                state_nx = (bit_cnt == '0) ? IDLE : GAP;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            dly_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_nx;
            if (capture) begin
                sr      <= shifted[LEN-2:0];
                bit_cnt <= complete ? '0 : bit_cnt + BW'(1);
            end else if (tmo) begin
                sr      <= '0;
                bit_cnt <= '0;
            end
            // dly_cnt counts the strobe cycle itself, so the pulse lands RDY_DLY cycles later.
            if (capture)
                dly_cnt <= DW'(1);
            else if (state == DELAY && dly_cnt < DLY_LAST)
                dly_cnt <= dly_cnt + DW'(1);
            if (state != GAP)
                gap_cnt <= '0;
            else if (gap_cnt < GAP_LAST)
                gap_cnt <= gap_cnt + GW'(1);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_word        <= '0;
            o_valid       <= 1'b0;
            o_err_proto   <= 1'b0;
            o_err_timeout <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            if (complete) begin
                if (!o_valid || i_ack) begin
                    o_word  <= shifted;
                    o_valid <= 1'b1;
                end
            end else if (o_valid && i_ack) begin
                o_valid <= 1'b0;
            end
            // A new error event beats a coincident clear.
            o_err_proto   <= (o_err_proto   && !i_clr) || proto;
            o_err_timeout <= (o_err_timeout && !i_clr) || tmo;
            o_overrun     <= (o_overrun     && !i_clr) || overrun_evt;
        end
    end

endmodule

// File: tb/tb_cfg_word_rx.sv
// Bench for cfg_word_rx: table-driven loopback word, directed corner cases and
// randomized traffic checked against a countdown/queue-style reference model.
module tb_cfg_word_rx;

    localparam int LEN = 7;
    localparam int RD  = 2;
    localparam int TO  = 8;

    logic clk = 1'b0;
    logic rst_n, clr, wr, d, ack, w1, w5;
    logic rdy, valid, ep, et, ov;
    logic [LEN-1:0] word;
    logic [2:0] bc;
    logic rdy1, v1, ep1, et1, ov1, rdy5, v5, ep5, et5, ov5;
    logic [LEN-1:0] word1, word5;
    logic [2:0] bc1, bc5;

    int n_vec = 0;
    int n_err = 0;

    cfg_word_rx #(.LEN(LEN), .RDY_DLY(RD), .TIMEOUT(TO)) u0 (
        .clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_col_write(wr), .i_data(d),
        .i_ack(ack), .o_col_rdy(rdy), .o_word(word), .o_valid(valid),
        .o_bit_cnt(bc), .o_err_proto(ep), .o_err_timeout(et), .o_overrun(ov));

    cfg_word_rx #(.LEN(LEN), .RDY_DLY(1), .TIMEOUT(0)) u1 (
        .clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_col_write(w1), .i_data(d),
        .i_ack(ack), .o_col_rdy(rdy1), .o_word(word1), .o_valid(v1),
        .o_bit_cnt(bc1), .o_err_proto(ep1), .o_err_timeout(et1), .o_overrun(ov1));

    cfg_word_rx #(.LEN(LEN), .RDY_DLY(5), .TIMEOUT(0)) u5 (
        .clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_col_write(w5), .i_data(d),
        .i_ack(ack), .o_col_rdy(rdy5), .o_word(word5), .o_valid(v5),
        .o_bit_cnt(bc5), .o_err_proto(ep5), .o_err_timeout(et5), .o_overrun(ov5));

    always #5 clk = ~clk;

    // Reference model: busy = cycles left until the ready pulse (pulse when 1).
    int m_busy, m_bits, m_sr, m_word, m_gap;
    bit m_valid, m_ep, m_et, m_ov;

    function automatic void m_reset();
        m_busy = 0; m_bits = 0; m_sr = 0; m_word = 0; m_gap = 0;
        m_valid = 0; m_ep = 0; m_et = 0; m_ov = 0;
    endfunction

    function automatic void m_edge(bit w, bit dd, bit a, bit c);
        bit busy  = (m_busy > 0);
        bit cap   = w && !busy;
        bit pe    = w && busy;
        bit ingap = !busy && (m_bits > 0);
        bit te    = ingap && !w && (TO > 0) && (m_gap + 1 >= TO);
        bit comp  = cap && (m_bits == LEN - 1);
        int nsr   = ((m_sr << 1) | int'(dd)) & ((1 << LEN) - 1);
        bit oe    = comp && m_valid && !a;
        m_gap = (ingap && !w && !te) ? m_gap + 1 : 0;
        if (m_busy > 0) m_busy--;
        if (cap) begin
            m_busy = RD;
            m_sr   = nsr;
            m_bits = comp ? 0 : m_bits + 1;
        end
        if (te) begin m_sr = 0; m_bits = 0; end
        if (comp) begin
            if (!oe) begin m_word = nsr; m_valid = 1; end
        end else if (m_valid && a) m_valid = 0;
        if (c) begin m_ep = 0; m_et = 0; m_ov = 0; end
        if (pe) m_ep = 1;
        if (te) m_et = 1;
        if (oe) m_ov = 1;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("rdy",     32'(rdy),   32'(m_busy == 1));
        chk("valid",   32'(valid), 32'(m_valid));
        chk("word",    32'(word),  32'(m_word));
        chk("bit_cnt", 32'(bc),    32'(m_bits));
        chk("flags",   32'({ep, et, ov}), 32'({m_ep, m_et, m_ov}));
    endtask

    task automatic step(bit w, bit dd, bit a, bit c);
        wr = w; d = dd; ack = a; clr = c;
        m_edge(w, dd, a, c);
        @(posedge clk); #1;
        check_model();
    endtask

    task automatic send_word(logic [LEN-1:0] v, bit ack_last);
        for (int i = LEN - 1; i >= 0; i--) begin
            step(1'b1, v[i], (i == 0) && ack_last, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    typedef struct {
        bit w, d, a, c;
        bit rdy, valid;
        int bc;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [LEN-1:0] lb;
        lb = 7'b1011001;
        // strobe / delay / ready rhythm for each bit of the loopback word
        for (int k = 0; k < LEN; k++) begin
            tbl.push_back('{1'b1, lb[LEN-1-k], 1'b0, 1'b0, 1'b0, k == LEN-1, (k + 1) % LEN});
            tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, k == LEN-1, (k + 1) % LEN});
            tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, k == LEN-1, (k + 1) % LEN});
        end

        wr = 0; d = 0; ack = 0; clr = 0; w1 = 0; w5 = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outs", 32'({rdy, valid, word, bc, ep, et, ov}), 32'd0);
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            wr = tbl[i].w; d = tbl[i].d; ack = tbl[i].a; clr = tbl[i].c;
            m_edge(tbl[i].w, tbl[i].d, tbl[i].a, tbl[i].c);
            @(posedge clk); #1;
            chk("tbl_rdy",   32'(rdy),   32'(tbl[i].rdy));
            chk("tbl_valid", 32'(valid), 32'(tbl[i].valid));
            chk("tbl_bc",    32'(bc),    32'(tbl[i].bc));
            check_model();
        end
        chk("loopback_word", 32'(word), 32'h59);

        // ready latency for RDY_DLY = 1 and 5
        w1 = 1'b1; w5 = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        w1 = 1'b0; w5 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            chk("rdy_dly1", 32'(rdy1), 32'(k == 1));
            chk("rdy_dly5", 32'(rdy5), 32'(k == 5));
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("side_bc", 32'({bc1, bc5}), 32'({3'd1, 3'd1}));
        chk("side_idle", 32'({v1, ep1, et1, ov1, v5, ep5, et5, ov5, word1 | word5}), 32'd0);

        // overrun: word 0x59 still unaccepted
        send_word(7'h12, 1'b0);
        chk("ovr_kept", 32'({valid, word}), 32'({1'b1, 7'h59}));
        chk("ovr_flag", 32'(ov), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_clr", 32'(ov), 32'd0);
        send_word(7'h34, 1'b1);
        chk("ack_load", 32'({valid, word, ov}), 32'({1'b1, 7'h34, 1'b0}));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ack_clr", 32'(valid), 32'd0);

        // timeout: 3 bits then silence
        step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("tmo_before", 32'({et, bc}), 32'({1'b0, 3'd3}));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("tmo_after", 32'({et, bc}), 32'({1'b1, 3'd0}));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(7'h4D, 1'b0);
        chk("tmo_word", 32'({valid, word}), 32'({1'b1, 7'h4D}));
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // protocol error: second strobe while delaying
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("proto_set", 32'({ep, bc}), 32'({1'b1, 3'd1}));
        step(1'b0, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("proto_clr", 32'(ep), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("proto_clr_race", 32'({ep, bc}), 32'({1'b1, 3'd2}));
        step(1'b0, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);

        // async reset mid-word
        step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst", 32'({rdy, bc}), 32'({1'b1, 3'd4}));
        rst_n = 1'b0;
        #1;
        chk("mid_rst", 32'({rdy, valid, word, bc, ep, et, ov}), 32'd0);
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_word(7'h2A, 1'b0);
        chk("post_rst_word", 32'({valid, word}), 32'({1'b1, 7'h2A}));

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 29) == 0)
                repeat (10) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            step(1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
